// File: rtl/fp_mant_divider.sv
// fp_mant_divider: sequential radix-2 restoring divider for normalized 24-bit
// binary32 mantissas (hidden bit included). Produces a 26-bit quotient
// floor(A*2^25/B) plus a sticky bit, one quotient bit per cycle.
// Optional feature macro: EARLY_TERM_EN (stop as soon as the remainder is zero).
`timescale 1ns/1ps

module fp_mant_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] A,
    input  logic [23:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [25:0] Q,
    output logic        sticky,
    output logic        err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [25:0] rem;
    logic [23:0] div;
    logic [4:0]  cnt;
    logic [25:0] quo;
    logic        sticky_r;
    logic        err_r;

    logic [26:0] diff;
    logic        q_bit;
    logic [25:0] pre_rem;
    logic [25:0] quo_next;
`ifdef EARLY_TERM_EN
    logic [25:0] quo_fill;
    logic        rem_zero;
`endif

    // One restoring step: trial subtract, keep the difference when non-negative.
    always_comb begin
        diff     = {1'b0, rem} - {3'b000, div};
        q_bit    = ~diff[26];
        pre_rem  = q_bit ? diff[25:0] : rem;
        quo_next = {quo[24:0], q_bit};
`ifdef EARLY_TERM_EN
        // Remaining bits below the current one are all zero once the remainder is.
        quo_fill = quo_next << cnt;
        rem_zero = (pre_rem == '0);
`endif
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign Q         = quo;
    assign sticky    = sticky_r;
    assign err       = err_r;

    // Control FSM and iterative datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            quo      <= '0;
            sticky_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!A[23] || !B[23]) begin
                            state    <= DONE;
                            quo      <= '1;
                            sticky_r <= 1'b1;
                            err_r    <= 1'b1;
                        end else begin
                            state    <= RUN;
                            rem      <= {2'b00, A};
                            div      <= B;
                            quo      <= '0;
                            cnt      <= 5'd25;
                            sticky_r <= 1'b0;
                            err_r    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // R < 2B holds, so the shifted-out MSB is always zero.
                    quo <= quo_next;
                    rem <= pre_rem << 1;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state    <= DONE;
                        sticky_r <= |pre_rem;
                    end
`ifdef EARLY_TERM_EN
                    if (rem_zero) begin
                        state    <= DONE;
                        quo      <= quo_fill;
                        sticky_r <= 1'b0;
                        cnt      <= '0;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
